switch_debounce: RTL and testbench
==================================

# switch_debounce

Debounces and synchronises the raw board DIP switches before they reach the MMIO peripheral's `switch[7:0]` input, which software reads at address 0x40000014. Each bit passes through a 2-flop synchroniser and a per-bit stability counter. Each bit also produces one-cycle rise and fall strobes and a sticky change flag that software clears. The block sits directly upstream of the peripheral's switch read path, in the same clock domain.

## Interface
- `WIDTH`, 8: number of switch bits.
- `DEBOUNCE_CYCLES`, 1000000: consecutive cycles a synchronised bit must differ from its debounced value before the debounced value updates. Legal range is ≥ 2. The counter width is $clog2(DEBOUNCE_CYCLES).
- `clk`, input, 1: system clock, same clock as the peripheral.
- `reset`, input, 1: synchronous, active-high reset.
- `sw_raw`, input, WIDTH: asynchronous, bouncing switch pins.
- `switch`, output, WIDTH: debounced level. Connects to the peripheral's `switch` input.
- `rise`, output, WIDTH: 1-cycle strobe per bit when its debounced value goes 0→1.
- `fall`, output, WIDTH: 1-cycle strobe per bit when its debounced value goes 1→0.
- `chg_flag`, output, 1: sticky. Set by any rise or fall.
- `chg_clr`, input, 1: 1-cycle pulse that clears `chg_flag`.

## Operation
- **Synchroniser:** `s1 <= sw_raw; s <= s1;` per bit. This is the only use of `sw_raw`.
- **Per-bit counter `cnt[i]`:**
  - If `s[i] == switch[i]`, then `cnt[i] <= 0`. Any bounce back to the old level restarts the count.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`, then `switch[i] <= s[i]` and `cnt[i] <= 0`. `rise[i]`/`fall[i]` are registered in the same edge.
  - Else `cnt[i] <= cnt[i] + 1`.
- Counter arithmetic never wraps. A counter is always cleared at or before the terminal count.
- Bits are fully independent. Several bits may update in the same cycle, each with its own strobe.
- `rise` and `fall` are registered outputs. Each is high for exactly one cycle per debounced transition. `rise[i]` and `fall[i]` are never both high.
- **`chg_flag` next state:**
  - 1 if any `rise`/`fall` update happens this edge.
  - Otherwise 0 if `chg_clr`.
  - Otherwise holds.
  - When a set and a clear coincide, the set wins.
- **Reset (synchronous, `reset`=1 at a rising edge):**
  - `s1`, `s`, `switch`, `cnt`, `rise`, `fall`, `chg_flag` all go to 0.
  - Reset overrides every other update in that cycle, including a pending terminal count. A reset mid-count discards the progress.
- **After reset:** switches that are physically on produce a normal debounced rise. Per the latency rule below, this occurs 2+DEBOUNCE_CYCLES edges after reset deasserts, and also sets `chg_flag`.

## Timing
- **Latency:** `sw_raw` changes and then stays stable. It is sampled into `s1` at edge E, and `s` follows at E+1. `switch` and the strobe update at edge E+1+DEBOUNCE_CYCLES.
- **Glitch rejection:** a pulse on `s[i]` lasting ≤ DEBOUNCE_CYCLES-1 cycles never changes `switch[i]`.
- **Strobe timing:** strobes deassert on the edge after assertion. `chg_flag` rises on the same edge as the strobe.
- **`chg_clr`:** takes effect at the next edge. The flag reads 0 in the following cycle unless a new transition coincides with the clear.
- **Combinational paths:** none from inputs to outputs. All outputs are registered.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `WIDTH`=8.
- **Reset state:** hold `reset` for 3 cycles with `sw_raw`=8'hFF. Required: `switch`=0, `rise`/`fall`=0 and `chg_flag`=0 during reset. After release, `switch`=8'hFF appears exactly 6 edges later, `rise`=8'hFF for 1 cycle, and `chg_flag`=1.
- **Clean step:** `sw_raw[3]` goes 0→1 at edge E. Required: `switch[3]`=1 and a `rise[3]` pulse at E+5, with no other bits affected. Returning to 0 gives `fall[3]` at the corresponding edge.
- **Bounce rejection:** `sw_raw[0]` toggles 1,0,1,0 every 2 cycles, then holds at 1. Required: no update until 4 consecutive cycles of `s[0]`=1. Exactly one `rise[0]` pulse and no `fall[0]`.
- **Simultaneous bits:** `sw_raw` goes 8'h00→8'hA5 in one cycle. Required: `switch`=8'hA5 and `rise`=8'hA5 on the same single edge.
- **Flag clear race:** pulse `chg_clr` on the same edge a `fall[7]` occurs. Required: `chg_flag` stays 1. A later lone `chg_clr` drives it to 0 the next cycle.
- **Reset mid-count:** assert `reset` 2 cycles into a pending change. Required: no strobe, `switch`=0, and the count restarts from 0 after release.

Source files
------------

// File: rtl/switch_debounce.sv
// Synchronises and debounces raw DIP switch pins, producing debounced levels,
// per-bit rise/fall strobes and a sticky software-clearable change flag.
module switch_debounce #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg_flag,
    input  logic             chg_clr
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_switch;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_chg_flag;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_differs;
    logic [WIDTH-1:0] w_update;
    logic             w_any_update;

    // A bit updates only after it has disagreed with its debounced level for
    // DEBOUNCE_CYCLES consecutive edges; the counter never passes CNT_TERM.
    always_comb begin
        w_differs = r_s ^ r_switch;
        w_update  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_update[i] = w_differs[i] && (r_cnt[i] == CNT_TERM);
        end
        w_any_update = |w_update;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1       <= '0;
            r_s        <= '0;
            r_switch   <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_chg_flag <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= sw_raw;
            r_s  <= r_s1;
            for (int i = 0; i < WIDTH; i++) begin
                if (!w_differs[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_update[i]) begin
                    r_switch[i] <= r_s[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                end
            end
            r_rise <= w_update & r_s;
            r_fall <= w_update & ~r_s;
            // A transition on the same edge as a clear keeps the flag set.
            if (w_any_update) begin
                r_chg_flag <= 1'b1;
            end else if (chg_clr) begin
                r_chg_flag <= 1'b0;
            end
        end
    end

    assign switch   = r_switch;
    assign rise     = r_rise;
    assign fall     = r_fall;
    assign chg_flag = r_chg_flag;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce with DEBOUNCE_CYCLES=4: directed
// stimulus pushes expected strobe events, a negedge monitor pops and compares.
module tb_switch_debounce;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int EW = 57;  // {cycle[31:0], switch, rise, fall, flag}

  logic         clk = 1'b0;
  logic         reset;
  logic         chg_clr;
  logic         chg_flag;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_dut;
  logic [W-1:0] rise;
  logic [W-1:0] fall;

  int unsigned  cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  bit           done = 1'b0;
  logic [W-1:0] exp_sw;
  logic [EW-1:0] exp_q[$];

  switch_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .switch   (sw_dut),
    .rise     (rise),
    .fall     (fall),
    .chg_flag (chg_flag),
    .chg_clr  (chg_clr)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int unsigned at, input logic [W-1:0] sw,
                          input logic [W-1:0] r, input logic [W-1:0] f);
    exp_q.push_back({at, sw, r, f, 1'b1});
  endtask

  // drive a settled level; any change is expected 2+D edges after this cycle
  task automatic apply(input logic [W-1:0] v);
    logic [W-1:0] ch;
    ch = v ^ exp_sw;
    sw_raw = v;
    if (ch != '0) begin
      push_exp(cyc + 2 + D, v, ch & v, ch & ~v);
      exp_sw = v;
    end
    tick(D + 4);
    check("settled_level", sw_dut, exp_sw);
  endtask

  // monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!done && ((rise | fall) != '0)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: rise=%h fall=%h at cycle %0d, expected none", rise, fall, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_cycle", 64'(cyc), 64'(e[56:25]));
        check("strobe_switch", 64'(sw_dut), 64'(e[24:17]));
        check("strobe_rise", 64'(rise), 64'(e[16:9]));
        check("strobe_fall", 64'(fall), 64'(e[8:1]));
        check("strobe_flag", 64'(chg_flag), 64'(e[0]));
      end
    end
  end

  // driver
  initial begin
    reset   = 1'b1;
    chg_clr = 1'b0;
    sw_raw  = 8'hFF;
    exp_sw  = 8'h00;

    // reset state
    repeat (3) begin
      @(negedge clk);
      check("reset_switch", sw_dut, 8'h00);
      check("reset_rise", rise, 8'h00);
      check("reset_fall", fall, 8'h00);
      check("reset_flag", chg_flag, 1'b0);
    end
    reset = 1'b0;
    push_exp(cyc + 2 + D, 8'hFF, 8'hFF, 8'h00);
    exp_sw = 8'hFF;
    tick(5);
    check("pre_update_level", sw_dut, 8'h00);
    tick(3);
    check("post_reset_level", sw_dut, 8'hFF);
    check("flag_sticky", chg_flag, 1'b1);
    chg_clr = 1'b1;
    tick(1);
    chg_clr = 1'b0;
    check("flag_clear", chg_flag, 1'b0);

    // clean step on bit 3
    apply(8'h00);
    apply(8'h08);
    apply(8'h00);

    // bounce rejection on bit 0
    sw_raw = 8'h01; tick(2);
    sw_raw = 8'h00; tick(2);
    sw_raw = 8'h01; tick(2);
    sw_raw = 8'h00; tick(2);
    sw_raw = 8'h01;
    push_exp(cyc + 2 + D, 8'h01, 8'h01, 8'h00);
    exp_sw = 8'h01;
    tick(D + 4);
    check("bounce_level", sw_dut, 8'h01);
    apply(8'h00);

    // simultaneous bits
    apply(8'hA5);

    // flag clear racing a fall on bit 7
    chg_clr = 1'b1;
    tick(1);
    chg_clr = 1'b0;
    check("flag_preclear", chg_flag, 1'b0);
    sw_raw = 8'h25;
    push_exp(cyc + 2 + D, 8'h25, 8'h00, 8'h80);
    exp_sw = 8'h25;
    tick(5);
    chg_clr = 1'b1;
    tick(1);
    chg_clr = 1'b0;
    tick(1);
    check("flag_after_race", chg_flag, 1'b1);
    chg_clr = 1'b1;
    tick(1);
    chg_clr = 1'b0;
    check("flag_lone_clear", chg_flag, 1'b0);
    tick(2);

    // reset two cycles into a pending change of bit 1
    sw_raw = 8'h27;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset_switch", sw_dut, 8'h00);
    check("midreset_rise", rise, 8'h00);
    check("midreset_fall", fall, 8'h00);
    check("midreset_flag", chg_flag, 1'b0);
    exp_sw = 8'h00;
    push_exp(cyc + 2 + D, 8'h27, 8'h27, 8'h00);
    exp_sw = 8'h27;
    tick(D + 4);
    check("midreset_level", sw_dut, 8'h27);
    check("midreset_flag_set", chg_flag, 1'b1);

    // final report
    tick(2);
    done = 1'b1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
